// File: rtl/sync_sp_ram_stream_adapter.sv
// Valid/ready front end for a synchronous single-port 32-bit byte-enable RAM.
// Admission is credit-based so read data returning at fixed latency always has a response slot.
`timescale 1ns/1ps
module sync_sp_ram_stream_adapter #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned RSP_DEPTH   = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  ReqValid_SI,
    output logic                  ReqReady_SO,
    input  logic                  ReqWrEn_SI,
    input  logic [3:0]            ReqBEn_SI,
    input  logic [31:0]           ReqWrData_DI,
    input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
    output logic                  RspValid_SO,
    input  logic                  RspReady_SI,
    output logic [31:0]           RspRdData_DO,
    output logic                  RamCSel_SO,
    output logic                  RamWrEn_SO,
    output logic [3:0]            RamBEn_SO,
    output logic [31:0]           RamWrData_DO,
    output logic [ADDR_WIDTH-1:0] RamAddr_DO,
    input  logic [31:0]           RamRdData_DI
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);

    if (!(RAM_LATENCY == 1 || RAM_LATENCY == 2)) begin : g_bad_latency
        $error("RAM_LATENCY must be 1 or 2");
    end
    if (RSP_DEPTH < 1) begin : g_bad_depth
        $error("RSP_DEPTH must be at least 1");
    end

    logic [RAM_LATENCY-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [31:0]            mem_q [RSP_DEPTH];

    logic             rd_fire;
    logic             push;
    logic             pop;
    logic [SUM_W-1:0] in_flight;
    logic [SUM_W-1:0] used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Every accepted read holds a credit until its response pops, counted as
    // tagged reads still inside the RAM plus entries already in the FIFO.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            in_flight = in_flight + SUM_W'(tag_q[i]);
        end
        used = in_flight + SUM_W'(count_q);
    end

    assign ReqReady_SO  = !Rst_RI && (used < SUM_W'(RSP_DEPTH));
    assign RamCSel_SO   = ReqValid_SI && ReqReady_SO;
    assign RamWrEn_SO   = ReqWrEn_SI;
    assign RamBEn_SO    = ReqBEn_SI;
    assign RamWrData_DO = ReqWrData_DI;
    assign RamAddr_DO   = ReqAddr_DI;

    assign rd_fire      = RamCSel_SO && !ReqWrEn_SI;
    assign push         = tag_q[RAM_LATENCY-1];
    assign RspValid_SO  = !Rst_RI && (count_q != '0);
    assign RspRdData_DO = mem_q[rd_ptr_q];
    assign pop          = RspValid_SO && RspReady_SI;

    always_comb begin
        tag_d    = RAM_LATENCY'({tag_q, rd_fire});
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            tag_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            tag_q    <= tag_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Response storage carries data only, so it is left out of reset.
    always_ff @(posedge Clk_CI) begin
        if (push) begin
            mem_q[wr_ptr_q] <= RamRdData_DI;
        end
    end

    a_no_overflow: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
        !(push && (count_q == CNT_FULL)))
        else $error("response FIFO overflow");

endmodule

// File: doc/sync_sp_ram_stream_adapter.md
# sync_sp_ram_stream_adapter

Valid/ready front end for the synchronous single-port N x 32 byte-enable RAM. Converts a request stream (read or byte-masked write) into the RAM's chip-select/write-enable/byte-enable/address strobes and captures read data, delayed by the RAM's fixed latency, into a small response FIFO. The RAM cannot stall, so admission is credit-based: a request is only accepted if its response is guaranteed a FIFO slot. Sits directly upstream of the RAM and drives all of its inputs.

## Interface
- ADDR_WIDTH, 10, RAM address width; must match the RAM instance.
- RAM_LATENCY, 1, cycles from RAM sampling to valid read data: 1 without RAM output registers, 2 with them. Only 1 and 2 are legal.
- RSP_DEPTH, 4, response FIFO entries, minimum 1. Full throughput requires RSP_DEPTH >= RAM_LATENCY+2.

Ports:
- Clk_CI  in  1  clock; all state updates on the rising edge.
- Rst_RI  in  1  reset, synchronous, active-high.
- ReqValid_SI  in  1  request valid.
- ReqReady_SO  out  1  request ready.
- ReqWrEn_SI  in  1  1 = write, 0 = read.
- ReqBEn_SI  in  4  write byte enables; bit i covers data bits [8i+7:8i].
- ReqWrData_DI  in  32  write data.
- ReqAddr_DI  in  ADDR_WIDTH  word address.
- RspValid_SO  out  1  read response valid.
- RspReady_SI  in  1  read response ready.
- RspRdData_DO  out  32  read data; meaningful only while RspValid_SO=1.
- RamCSel_SO, RamWrEn_SO  out  1 each  to RAM chip select / write enable.
- RamBEn_SO  out  4  to RAM byte enables.
- RamWrData_DO  out  32  to RAM write data.
- RamAddr_DO  out  ADDR_WIDTH  to RAM address.
- RamRdData_DI  in  32  from RAM read data.

## Operation
- Handshake: a transfer happens in a cycle where valid and ready are both 1. Once ReqValid_SI is asserted, it and the payload stay stable until accepted. Once RspValid_SO is asserted, it and the data stay stable until accepted.
- ReqReady_SO = !Rst_RI && (InFlight + Count < RSP_DEPTH).
  - It depends on registered state only, never on request inputs.
  - The credit check applies to both reads and writes.
- RAM drive is combinational:
  - RamCSel_SO = ReqValid_SI & ReqReady_SO.
  - RamWrEn_SO = ReqWrEn_SI.
  - RamBEn_SO, RamWrData_DO and RamAddr_DO pass through from the request.
- Writes generate no response. The RAM's read data during a write cycle is discarded.
- Read tracking: a RAM_LATENCY-deep shift register of read-tag bits.
  - The tag entering the shift register is 1 for an accepted read, 0 otherwise.
  - InFlight = number of set tags.
  - When a set tag exits, RamRdData_DI is pushed into the FIFO on that edge.
- FIFO: circular buffer with read pointer, write pointer and Count (0..RSP_DEPTH).
  - RspValid_SO = (Count != 0). RspRdData_DO = the head entry.
  - Pop happens on the response handshake.
  - Push and pop in the same cycle leave Count unchanged.
  - Pointers wrap from RSP_DEPTH-1 to 0; non-power-of-two depths are legal.
- Credits: a slot is reserved from request acceptance until the response pops. There is no pop look-ahead, so a pop frees its credit in the next cycle.
- Overflow is impossible by construction. An assertion flags a push when Count==RSP_DEPTH.
- Reset (Rst_RI=1 on an edge) clears tags, pointers and Count.
  - Reads in flight are dropped, and their returning data is ignored.
  - While Rst_RI=1: ReqReady_SO=0, RamCSel_SO=0, RspValid_SO=0.

## Timing
- Read accepted in cycle t: the RAM samples at the end of t, data is pushed at the end of t+RAM_LATENCY, and RspValid_SO=1 in cycle t+RAM_LATENCY+1. Request-to-response latency is RAM_LATENCY+1.
- A write accepted in cycle t is written to the RAM at the end of t. A read of the same address accepted in t+1 returns the new data.
- Reset values of outputs: ReqReady_SO=0 during reset and RSP_DEPTH>0 ⇒ 1 in the first cycle after; RspValid_SO=0. RspRdData_DO is undefined when not valid.
- Throughput: one request per cycle sustained, provided RSP_DEPTH >= RAM_LATENCY+2 and RspReady_SI stays high.

## Test plan
- RAM_LATENCY=1, back-to-back writes 0xA5A5_0000+i to addr i (i=0..7, BEn=0xF), then 8 back-to-back reads, RspReady_SI=1 → responses in order with value 0xA5A5_0000+i, first one 2 cycles after its request, no ready gaps.
- Write 0x11223344 to addr 3 with BEn=0xF, then 0xFFFFFFFF with BEn=0x5, then read addr 3 → 0x11FF33FF.
- RAM_LATENCY=2, RSP_DEPTH=4, RspReady_SI=0, 6 reads offered → exactly 4 accepted and ReqReady_SO=0 from then on. Raise RspReady_SI → 4 responses in order, after which ReqReady_SO returns to 1 and the remaining 2 reads complete.
- Random valid/ready toggling, 10k mixed reads and writes against a scoreboard model → data matches, never more than RSP_DEPTH outstanding, stability rules hold on both streams.
- Assert Rst_RI for 1 cycle with 2 reads in flight and 1 entry in the FIFO → RspValid_SO=0 after reset, no stale response ever appears, and the next read returns correct data.
- RSP_DEPTH=3 (non-power-of-two), 20 reads with RspReady_SI alternating 1/0 → correct order across pointer wrap, Count stays within 0..3.
